div_radix2: RTL and testbench
=============================

Name: div_radix2

Overview:
- Iterative, multi-cycle 32-bit integer divider for the execute stage of the 5-stage MIPS pipeline.
- Instantiated inside the ALU for DIV and DIVU. Its 64-bit result {remainder, quotient} feeds the HI/LO write path, which then travels through the M and W pipeline registers into the hilo register.
- Its stall output drives the hazard unit's execute-stage divide stall, which freezes the F, D and E stages while a division is in flight.

Parameters:
- WIDTH, 32, operand width. The result is 2*WIDTH bits.
- CNT_W, 6, width of the iteration counter. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active high.
- start_i  input  1  execute-stage instruction is DIV or DIVU; held high while stalled.
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU.
- a_i  input  WIDTH  dividend (forwarded rs).
- b_i  input  WIDTH  divisor (forwarded rt).
- annul_i  input  1  flushE; cancels the in-flight operation.
- result_o  output  2*WIDTH  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
- ready_o  output  1  result valid; one-cycle pulse.
- stall_o  output  1  request to hold the F, D and E stages.

Behaviour:
- Clock and reset: one clock domain. rst is asynchronous and active high.
- Reset values: state=IDLE, counter=0, partial remainder=0, quotient register=0, result_o=0, ready_o=0, stall_o=0. Reset asserted mid-operation aborts immediately with no ready_o.
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall_o = start_i & ~annul_i (combinational).
  - On start_i & ~annul_i, latch the following and go to BUSY:
    - |a| and |b| when signed_i, otherwise the raw operands;
    - the sign of the quotient (a[31]^b[31]) & signed_i;
    - the sign of the remainder a[31] & signed_i;
    - counter=0.
  - Divisor == 0: go straight to DONE with quotient=32'hFFFF_FFFF and remainder=a_i (raw). Latency is 1 cycle.
- BUSY:
  - stall_o=1.
  - Each cycle performs one restoring step on the 65-bit {rem, quo}: shift left 1, trial-subtract the divisor from the upper 33 bits; if the result is non-negative, keep it and set quo[0]=1.
  - counter increments each cycle. After the 32nd step (counter==31) go to DONE.
- DONE:
  - ready_o=1 and stall_o=0 for exactly one cycle; the pipeline advances at the end of that cycle. Next state is IDLE.
  - result_o applies sign correction: the quotient is negated if the quotient sign is set, the remainder is negated if the remainder sign is set.
  - start_i is ignored in DONE; a back-to-back divide starts from IDLE on the following cycle.
- Latency: start accepted at cycle T, BUSY for T+1..T+32, ready_o at T+33. The hazard unit sees 33 stall cycles.
- result_o is registered. It is held after DONE until the next accepted start and is not cleared in IDLE.
- annul_i:
  - In BUSY or IDLE: return to / stay in IDLE on the next edge. No ready_o; result_o is unchanged.
  - In DONE: ready_o still pulses. The hilo write is squashed downstream by the flush.
- Overflow, 0x8000_0000 / -1 signed: quotient=0x8000_0000, remainder=0 (falls out of modular negation). No trap.
- Simultaneous start_i and annul_i in IDLE: annul wins; no start, stall_o=0.
- Operands are sampled only in IDLE. Changes to a_i/b_i during BUSY are ignored.

Decomposition:
- Shared package mips_defs holds:
  - state encodings DIV_IDLE=2'b00, DIV_BUSY=2'b01, DIV_DONE=2'b10;
  - DIV_ITER=32;
  - DIV_ZERO_QUO=32'hFFFF_FFFF.
- One sub-module: div_step, a combinational single restoring-division iteration. Inputs are the 65-bit {rem, quo} and the divisor; output is the next {rem, quo}.
- Sign pre/post-negation stays in div_radix2.

Test Plan:
- DIVU 100/7: start_i held → stall_o high 33 cycles, ready_o at T+33, result_o={32'd2, 32'd14}.
- DIV -7/2 (0xFFFF_FFF9 / 2): result_o={32'hFFFF_FFFF, 32'hFFFF_FFFD}, i.e. remainder -1, quotient -3. DIV 7/-2 → {32'd1, 32'hFFFF_FFFD}.
- Divide by zero, DIVU 5/0: ready_o at T+1, result_o={32'd5, 32'hFFFF_FFFF}, stall_o high one cycle only.
- Overflow, DIV 0x8000_0000 / 0xFFFF_FFFF → result_o={32'd0, 32'h8000_0000}, 33-cycle latency.
- annul_i pulsed at T+10 during BUSY → state returns to IDLE at T+11, stall_o=0, no ready_o, result_o unchanged. A new DIVU 9/3 then completes 33 cycles later with {0, 3}.
- Back-to-back DIVU 10/3 then 20/6: second start accepted the cycle after ready_o → results {1, 3} then {2, 3}. rst asserted mid-BUSY clears all outputs asynchronously.

Source files
------------

// File: rtl/div_radix2_pkg.sv
// mips_defs: shared divider state encodings and constants
package mips_defs;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_t;
  localparam int DIV_ITER = 32;
  localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on {rem, quo}
// acc     : current {rem[WIDTH:0], quo[WIDTH-1:0]}
// divisor : unsigned divisor magnitude
// nxt     : {rem, quo} after shift, trial subtract and quotient-bit insert
module div_step
  import mips_defs::*;
#(
  parameter int WIDTH = DIV_ITER
) (
  input  logic [2*WIDTH:0]   acc,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH:0]   nxt
);
  logic [2*WIDTH+1:0] sh;
  logic [WIDTH+1:0]   diff;
  assign sh   = {acc, 1'b0};
  // Top bit of diff is the borrow: set means the trial subtraction went negative.
  assign diff = sh[2*WIDTH+1:WIDTH] - {2'b00, divisor};
  assign nxt  = diff[WIDTH+1] ? sh[2*WIDTH:0] : {diff[WIDTH:0], sh[WIDTH-1:1], 1'b1};
endmodule

// File: rtl/div_radix2.sv
// div_radix2: iterative radix-2 signed/unsigned divider for the execute stage
// start_i/signed_i/a_i/b_i : divide request, sampled only in IDLE
// annul_i                  : flush, cancels a request or in-flight divide
// result_o                 : registered {remainder, quotient}, held until next start
// ready_o                  : one-cycle result-valid pulse
// stall_o                  : hold F/D/E while a divide is being accepted or computed
module div_radix2
  import mips_defs::*;
#(
  parameter int WIDTH = DIV_ITER,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o
);
  div_state_t state, next;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH:0] acc, acc_nxt;
  logic [WIDTH-1:0] divisor, a_abs, b_abs, quo, rem;
  logic qsign, rsign, go, last, zero;
  assign go    = start_i & ~annul_i;
  assign zero  = b_i == '0;
  assign last  = cnt == CNT_W'(WIDTH - 1);
  assign a_abs = (signed_i & a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_abs = (signed_i & b_i[WIDTH-1]) ? -b_i : b_i;
  assign quo   = acc_nxt[WIDTH-1:0];
  assign rem   = acc_nxt[2*WIDTH-1:WIDTH];
  div_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .divisor (divisor),
    .nxt     (acc_nxt)
  );
  always_comb begin
    next    = DIV_IDLE;
    stall_o = 1'b0;
    ready_o = 1'b0;
    case (state)
      DIV_IDLE: begin
        stall_o = go;
        next    = go ? (zero ? DIV_DONE : DIV_BUSY) : DIV_IDLE;
      end
      DIV_BUSY: begin
        stall_o = 1'b1;
        next    = annul_i ? DIV_IDLE : last ? DIV_DONE : DIV_BUSY;
      end
      DIV_DONE: ready_o = 1'b1;
      default:  next    = DIV_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      acc      <= '0;
      divisor  <= '0;
      qsign    <= 1'b0;
      rsign    <= 1'b0;
      result_o <= '0;
    end else begin
      state <= next;
      if (state == DIV_IDLE && go) begin
        cnt     <= '0;
        acc     <= {{(WIDTH+1){1'b0}}, a_abs};
        divisor <= b_abs;
        qsign   <= (a_i[WIDTH-1] ^ b_i[WIDTH-1]) & signed_i;
        rsign   <= a_i[WIDTH-1] & signed_i;
        // Divide by zero bypasses the iterations and reports the raw dividend.
        if (zero) result_o <= {a_i, WIDTH'(DIV_ZERO_QUO)};
      end else if (state == DIV_BUSY) begin
        cnt <= cnt + 1'b1;
        acc <= acc_nxt;
        // Final step: apply sign correction straight from the step output.
        if (last && !annul_i) result_o <= {rsign ? -rem : rem, qsign ? -quo : quo};
      end
    end
  end
endmodule

// File: tb/tb_div_radix2.sv
// tb_div_radix2: randomized self-checking bench for div_radix2 against an arithmetic model
module tb_div_radix2;
  logic clk = 1'b0;
  logic rst, start_i, signed_i, annul_i, ready_o, stall_o;
  logic [31:0] a_i, b_i;
  logic [63:0] result_o;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  div_radix2 dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .annul_i  (annul_i),
    .result_o (result_o),
    .ready_o  (ready_o),
    .stall_o  (stall_o)
  );
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    q = sa / sb;
    r = sa % sb;
    return {32'(r), 32'(q)};
  endfunction
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int stalls, output logic [63:0] res, output logic ds);
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = sgn; a_i = a; b_i = b;
    #1;
    stalls = int'(stall_o);
    lat = 0;
    res = 'x;
    ds = 1'bx;
    forever begin
      @(posedge clk); #1;
      lat++;
      a_i = $urandom;
      b_i = $urandom;
      if (ready_o) begin
        res = result_o;
        ds = stall_o;
        break;
      end
      stalls += int'(stall_o);
      if (lat >= 60) begin
        lat = -1;
        break;
      end
    end
    start_i = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0; a_i = '0; b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (result_o !== 64'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", result_o); end
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    rst = 1'b0;
  endtask
  task automatic test_divu_basic();
    int lat, st; logic [63:0] r; logic ds;
    run_div(1'b0, 32'd100, 32'd7, lat, st, r, ds);
    total++; if (lat !== 33) begin bad++; $display("FAIL divu_latency got=%0d exp=33", lat); end
    total++; if (st !== 33) begin bad++; $display("FAIL divu_stalls got=%0d exp=33", st); end
    total++; if (r !== {32'd2, 32'd14}) begin bad++; $display("FAIL divu_100_7 got=%h exp=%h", r, {32'd2, 32'd14}); end
    total++; if (ds !== 1'b0) begin bad++; $display("FAIL divu_done_stall got=%b exp=0", ds); end
  endtask
  task automatic test_signed();
    int lat, st; logic [63:0] r; logic ds;
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, lat, st, r, ds);
    total++; if (r !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin bad++; $display("FAIL div_m7_2 got=%h exp=ffffffff_fffffffd", r); end
    total++; if (lat !== 33) begin bad++; $display("FAIL div_m7_2_latency got=%0d exp=33", lat); end
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, lat, st, r, ds);
    total++; if (r !== {32'd1, 32'hFFFF_FFFD}) begin bad++; $display("FAIL div_7_m2 got=%h exp=00000001_fffffffd", r); end
  endtask
  task automatic test_div_zero();
    int lat, st; logic [63:0] r; logic ds;
    run_div(1'b0, 32'd5, 32'd0, lat, st, r, ds);
    total++; if (lat !== 1) begin bad++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    total++; if (st !== 1) begin bad++; $display("FAIL zero_stalls got=%0d exp=1", st); end
    total++; if (r !== {32'd5, 32'hFFFF_FFFF}) begin bad++; $display("FAIL zero_5_0 got=%h exp=00000005_ffffffff", r); end
    run_div(1'b1, 32'hFFFF_FFFB, 32'd0, lat, st, r, ds);
    total++; if (r !== {32'hFFFF_FFFB, 32'hFFFF_FFFF}) begin bad++; $display("FAIL zero_signed got=%h exp=fffffffb_ffffffff", r); end
  endtask
  task automatic test_overflow();
    int lat, st; logic [63:0] r; logic ds;
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, st, r, ds);
    total++; if (r !== {32'd0, 32'h8000_0000}) begin bad++; $display("FAIL overflow got=%h exp=00000000_80000000", r); end
    total++; if (lat !== 33) begin bad++; $display("FAIL overflow_latency got=%0d exp=33", lat); end
  endtask
  task automatic test_annul();
    int lat, st; logic [63:0] r, prev; logic ds, seen;
    prev = result_o;
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd50; b_i = 32'd7;
    repeat (10) begin @(posedge clk); #1; end
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL annul_stall got=%b exp=0", stall_o); end
    total++; if (result_o !== prev) begin bad++; $display("FAIL annul_result got=%h exp=%h", result_o, prev); end
    seen = ready_o;
    repeat (40) begin @(posedge clk); #1; seen |= ready_o; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL annul_no_ready got=%b exp=0", seen); end
    start_i = 1'b1; annul_i = 1'b1; a_i = 32'd8; b_i = 32'd2;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL start_annul_stall got=%b exp=0", stall_o); end
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0;
    seen = stall_o | ready_o;
    repeat (3) begin @(posedge clk); #1; seen |= stall_o | ready_o; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL start_annul_idle got=%b exp=0", seen); end
    run_div(1'b0, 32'd9, 32'd3, lat, st, r, ds);
    total++; if (r !== {32'd0, 32'd3}) begin bad++; $display("FAIL after_annul_9_3 got=%h exp=00000000_00000003", r); end
    total++; if (lat !== 33) begin bad++; $display("FAIL after_annul_latency got=%0d exp=33", lat); end
  endtask
  task automatic test_back_to_back();
    int lat, st; logic [63:0] r; logic ds;
    run_div(1'b0, 32'd10, 32'd3, lat, st, r, ds);
    total++; if (r !== {32'd1, 32'd3}) begin bad++; $display("FAIL b2b_first got=%h exp=00000001_00000003", r); end
    run_div(1'b0, 32'd20, 32'd6, lat, st, r, ds);
    total++; if (r !== {32'd2, 32'd3}) begin bad++; $display("FAIL b2b_second got=%h exp=00000002_00000003", r); end
    total++; if (lat !== 33) begin bad++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
  endtask
  task automatic test_random();
    int lat, st; logic [63:0] r, exp; logic ds, sgn; logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 15);
        2: b = (i % 6 == 0) ? 32'd0 : 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      exp = model(sgn, a, b);
      run_div(sgn, a, b, lat, st, r, ds);
      total++; if (r !== exp) begin bad++; $display("FAIL random_result s=%b a=%h b=%h got=%h exp=%h", sgn, a, b, r, exp); end
      total++; if (lat !== ((b == 32'd0) ? 1 : 33)) begin bad++; $display("FAIL random_latency b=%h got=%0d", b, lat); end
    end
  endtask
  task automatic test_reset_mid();
    logic seen;
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd1000; b_i = 32'd3;
    repeat (5) begin @(posedge clk); #1; end
    start_i = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (result_o !== 64'd0) begin bad++; $display("FAIL midreset_result got=%h exp=0", result_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL midreset_stall got=%b exp=0", stall_o); end
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL midreset_ready got=%b exp=0", ready_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= ready_o | stall_o; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midreset_quiet got=%b exp=0", seen); end
  endtask
  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_annul();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
